// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode and sequencer state encodings
package alu_pkg;
  localparam int CMD_W = 2;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(push_ok);
      rp    <= rp + AW'(pop_ok);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU ops, drives them one at a time and returns results
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int CMD_W  = 2,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [CMD_W-1:0] alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CMD_W-1:0] rsp_cmd,
  output logic             busy,
  output logic [7:0]       op_count
);
  import alu_pkg::*;
  localparam int FW = 2*WIDTH + CMD_W;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] head;
  logic [$clog2(DEPTH):0] fcount;
  logic full, empty, pop;
  assign pop       = state == S_IDLE && !empty;
  assign req_ready = !full;
  assign busy      = state != S_IDLE || fcount != '0;
  sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .pop   (pop),
    .din   ({req_cmd, req_a, req_b}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );
  // ALU inputs stay frozen from pop until the next pop so the result cannot glitch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      alu_cmd   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cmd   <= '0;
      op_count  <= '0;
    end else begin
      if (pop) begin
        {alu_cmd, alu_a, alu_b} <= head;
        cnt   <= CW'(SETTLE-1);
        state <= S_WAIT;
      end
      if (state == S_WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rsp_data  <= alu_out;
          rsp_cmd   <= alu_cmd;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
      end
      if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
        state     <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors plus multi-cycle corner sequences
module tb_alu_op_sequencer;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_valid2 = 0, rsp_ready = 1, rsp_ready2 = 1;
  logic [1:0] req_cmd = 0;
  logic [3:0] req_a = 0, req_b = 0;
  logic req_ready, rsp_valid, busy, req_ready2, rsp_valid2, busy2;
  logic [1:0] alu_cmd, rsp_cmd, alu_cmd2, rsp_cmd2;
  logic [3:0] alu_a, alu_b, alu_out, rsp_data, alu_a2, alu_b2, alu_out2, rsp_data2;
  logic [7:0] op_count, op_count2;
  function automatic logic [3:0] alu_ref(logic [1:0] c, logic [3:0] a, logic [3:0] b);
    return c == OP_ADD ? a + b : c == OP_SUB ? a - b : c == OP_AND ? a & b : a | b;
  endfunction
  assign alu_out  = alu_ref(alu_cmd, alu_a, alu_b);
  assign alu_out2 = alu_ref(alu_cmd2, alu_a2, alu_b2);
  alu_op_sequencer #(.WIDTH(4), .CMD_W(2), .DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cmd(rsp_cmd), .busy(busy), .op_count(op_count)
  );
  alu_op_sequencer #(.WIDTH(4), .CMD_W(2), .DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_cmd(alu_cmd2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_out(alu_out2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
    .rsp_cmd(rsp_cmd2), .busy(busy2), .op_count(op_count2)
  );
  typedef struct {
    logic [1:0] cmd;
    logic [3:0] a, b, res;
  } vec_t;
  vec_t vt[8];
  int nerr = 0, nchk = 0, exp_ops = 0;
  logic [5:0] exp_q[$];
  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    req_cmd = c;
    req_a = a;
    req_b = b;
    req_valid = 1;
    tick;
    req_valid = 0;
  endtask
  task automatic send(input int n, input int base);
    int i = 0, t = 0;
    logic acc;
    while (i < n && t < 200) begin
      req_cmd = 2'(base + i);
      req_a = 4'(3*i + base);
      req_b = 4'(5*i + 1);
      req_valid = 1;
      acc = req_ready;
      tick;
      if (acc) begin
        exp_q.push_back({req_cmd, alu_ref(req_cmd, req_a, req_b)});
        i++;
      end
      t++;
    end
    req_valid = 0;
    chk("send_accepted", i, n);
  endtask
  task automatic collect(input int n);
    int got = 0, t = 0;
    logic [5:0] e;
    while (got < n && t < 300) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("extra_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("order_data", rsp_data, e[3:0]);
          chk("order_cmd", rsp_cmd, e[5:4]);
        end
        got++;
        exp_ops++;
      end
      tick;
      t++;
    end
    chk("collect_count", got, n);
  endtask
  initial begin
    int t, seen;
    vt[0] = '{OP_ADD, 4'h1, 4'h2, 4'h3};
    vt[1] = '{OP_ADD, 4'h5, 4'hA, 4'hF};
    vt[2] = '{OP_ADD, 4'hF, 4'h1, 4'h0};
    vt[3] = '{OP_SUB, 4'h3, 4'h5, 4'hE};
    vt[4] = '{OP_SUB, 4'h0, 4'h1, 4'hF};
    vt[5] = '{OP_AND, 4'hC, 4'hA, 4'h8};
    vt[6] = '{OP_OR,  4'hC, 4'h3, 4'hF};
    vt[7] = '{OP_OR,  4'h0, 4'h0, 4'h0};
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    rst_n = 1;
    tick;
    // single-op latency with SETTLE=1
    req_cmd = OP_ADD; req_a = 4'h1; req_b = 4'h2; req_valid = 1;
    tick;
    req_valid = 0;
    chk("lat_e0_valid", rsp_valid, 0);
    chk("lat_e0_busy", busy, 1);
    tick;
    chk("lat_e1_valid", rsp_valid, 0);
    chk("lat_e1_alu_a", alu_a, 1);
    chk("lat_e1_alu_b", alu_b, 2);
    tick;
    chk("lat_e2_valid", rsp_valid, 1);
    chk("lat_e2_data", rsp_data, 3);
    chk("lat_e2_cmd", rsp_cmd, OP_ADD);
    tick;
    chk("lat_e3_valid", rsp_valid, 0);
    chk("lat_e3_count", op_count, 1);
    chk("lat_e3_busy", busy, 0);
    exp_ops = 1;
    for (int i = 0; i < 8; i++) begin
      push1(vt[i].cmd, vt[i].a, vt[i].b);
      t = 0;
      while (!rsp_valid && t < 10) begin
        tick;
        t++;
      end
      chk("vec_valid", rsp_valid, 1);
      chk("vec_data", rsp_data, vt[i].res);
      chk("vec_cmd", rsp_cmd, vt[i].cmd);
      tick;
      exp_ops++;
      chk("vec_op_count", op_count, exp_ops);
    end
    // back-pressure: one in flight plus DEPTH queued
    rsp_ready = 0;
    send(5, 1);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_busy", busy, 1);
    req_cmd = OP_OR; req_a = 4'h7; req_b = 4'h7; req_valid = 1;
    tick;
    req_valid = 0;
    chk("bp_still_full", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    tick;
    tick;
    tick;
    chk("bp_hold_data", rsp_data, exp_q[0][3:0]);
    chk("bp_hold_cmd", rsp_cmd, exp_q[0][5:4]);
    rsp_ready = 1;
    collect(5);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seen |= int'(rsp_valid);
      tick;
    end
    chk("bp_no_extra", seen, 0);
    chk("bp_idle", busy, 0);
    chk("bp_op_count", op_count, exp_ops);
    // simultaneous push/pop starting from FIFO full-1
    rsp_ready = 0;
    send(4, 2);
    chk("b2b_ready", req_ready, 1);
    fork
      send(6, 3);
      begin
        rsp_ready = 1;
        collect(10);
      end
    join
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("b2b_op_count", op_count, 8'(exp_ops));
    // SETTLE=3 instance
    req_cmd = OP_SUB; req_a = 4'h9; req_b = 4'h4; req_valid2 = 1;
    tick;
    req_valid2 = 0;
    req_a = 4'h0; req_b = 4'h0;
    tick;
    chk("s3_e1_alu_a", alu_a2, 9);
    chk("s3_e1_valid", rsp_valid2, 0);
    tick;
    chk("s3_e2_valid", rsp_valid2, 0);
    tick;
    chk("s3_e3_alu_b", alu_b2, 4);
    chk("s3_e3_valid", rsp_valid2, 0);
    tick;
    chk("s3_e4_valid", rsp_valid2, 1);
    chk("s3_e4_data", rsp_data2, 5);
    chk("s3_e4_cmd", rsp_cmd2, OP_SUB);
    tick;
    chk("s3_op_count", op_count2, 1);
    // asynchronous reset while an op is in WAIT and another is queued
    req_cmd = OP_ADD; req_a = 4'h6; req_b = 4'h6; req_valid = 1;
    tick;
    req_cmd = OP_AND; req_a = 4'hF; req_b = 4'h5;
    tick;
    req_valid = 0;
    chk("rw_loaded", alu_a, 6);
    rst_n = 0;
    #1;
    chk("rw_alu_a", alu_a, 0);
    chk("rw_alu_b", alu_b, 0);
    chk("rw_alu_cmd", alu_cmd, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_rsp_data", rsp_data, 0);
    chk("rw_req_ready", req_ready, 1);
    chk("rw_busy", busy, 0);
    chk("rw_op_count", op_count, 0);
    tick;
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen |= int'(rsp_valid) | int'(busy);
    end
    chk("rw_no_stale", seen, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
